mem_bridge: RTL and testbench

MEM_BRIDGE -- requirements
Module: mem_bridge

---
 rtl/mem_bridge_pkg.sv | 15 +
 rtl/mem_bridge_ws.sv | 28 ++
 rtl/mem_bridge.sv | 107 ++++++++++
 tb/tb_mem_bridge.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared processor-side bus definitions: bridge state encoding, default widths
// and the wait-state counter width.
package mem_bridge_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;
    localparam int WS_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_bridge_ws.sv
// Wait-state counter: loadable down-counter that saturates at zero.
// The zero flag is combinational from the count, so it is valid in the same cycle.
module ws_counter
    import mem_bridge_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [WS_W-1:0] load_val,
    input  logic            dec,
    output logic            zero
);

    logic [WS_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_bridge.sv
// Processor-to-async-SRAM bridge with a four-phase RRq/WRq/OK handshake.
// OK rises WAIT_STATES+2 edges after a request is sampled and holds until the request drops.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              RRq,
    input  logic              WRq,
    output logic              OK,
    inout  wire  [DATA_W-1:0] Data,
    output logic              Busy,
    output logic              Err,
    output logic [ADDR_W-1:0] SAddr,
    output logic [DATA_W-1:0] SDOut,
    input  logic [DATA_W-1:0] SDIn,
    output logic              SCE,
    output logic              SWE
);

    state_t            state;
    state_t            state_nxt;
    logic              is_rd;
    logic [DATA_W-1:0] rd_reg;
    logic              req;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;

    assign req = RRq | WRq;

    ws_counter u_ws (
        .clk      (Clk),
        .rst_n    (Rst),
        .load     (cnt_load),
        .load_val (WS_W'(WAIT_STATES)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = ACCESS;
                    cnt_load  = 1'b1;
                end
            end
            ACCESS: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                // A request still held here is the tail of the current handshake.
                if (!req) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state  <= IDLE;
            is_rd  <= 1'b0;
            SAddr  <= '0;
            SDOut  <= '0;
            rd_reg <= '0;
            Err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                SAddr <= Addr;
                is_rd <= RRq;
                // Simultaneous requests resolve to a read; the write data is dropped.
                if (!RRq) begin
                    SDOut <= Data;
                end
                if (RRq && WRq) begin
                    Err <= 1'b1;
                end
            end
            if (state == ACCESS && cnt_zero && is_rd) begin
                rd_reg <= SDIn;
            end
        end
    end

    // Outputs decode straight from state so reset drops them without waiting for an edge.
    assign OK   = (state == RESP);
    assign Busy = (state != IDLE);
    assign SCE  = (state == ACCESS);
    assign SWE  = (state == ACCESS) && !is_rd;
    assign Data = (state == RESP && is_rd) ? rd_reg : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench: three bridges (WAIT_STATES 1, 0, 3) share the request side, each with its own bus.
module tb_mem_bridge;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        RRq;
    logic        WRq;
    logic [19:0] Addr;
    logic [15:0] SDIn;
    logic [15:0] drv;
    logic        drv_en;

    logic        ok1, busy1, err1, sce1, swe1;
    logic [19:0] saddr1;
    logic [15:0] sdout1;
    wire  [15:0] data1;
    logic        ok0, busy0, err0, sce0, swe0;
    logic [19:0] saddr0;
    logic [15:0] sdout0;
    wire  [15:0] data0;
    logic        ok3, busy3, err3, sce3, swe3;
    logic [19:0] saddr3;
    logic [15:0] sdout3;
    wire  [15:0] data3;

    int n_chk;
    int n_fail;
    int cyc;
    int cyc_a;
    int n;
    logic seen_swe;

    always #5 Clk = ~Clk;

    assign data1 = drv_en ? drv : 16'hzzzz;
    assign data0 = drv_en ? drv : 16'hzzzz;
    assign data3 = drv_en ? drv : 16'hzzzz;

    mem_bridge #(.WAIT_STATES(1)) b1 (
        .Clk(Clk), .Rst(Rst), .Addr(Addr), .RRq(RRq), .WRq(WRq), .OK(ok1), .Data(data1),
        .Busy(busy1), .Err(err1), .SAddr(saddr1), .SDOut(sdout1), .SDIn(SDIn), .SCE(sce1), .SWE(swe1));
    mem_bridge #(.WAIT_STATES(0)) b0 (
        .Clk(Clk), .Rst(Rst), .Addr(Addr), .RRq(RRq), .WRq(WRq), .OK(ok0), .Data(data0),
        .Busy(busy0), .Err(err0), .SAddr(saddr0), .SDOut(sdout0), .SDIn(SDIn), .SCE(sce0), .SWE(swe0));
    mem_bridge #(.WAIT_STATES(3)) b3 (
        .Clk(Clk), .Rst(Rst), .Addr(Addr), .RRq(RRq), .WRq(WRq), .OK(ok3), .Data(data3),
        .Busy(busy3), .Err(err3), .SAddr(saddr3), .SDOut(sdout3), .SDIn(SDIn), .SCE(sce3), .SWE(swe3));

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        Rst = 1'b0; RRq = 1'b0; WRq = 1'b0; Addr = '0; SDIn = '0; drv = '0; drv_en = 1'b0;

        // Reset forces outputs before any clock edge.
        #3;
        chk("rst ok1", ok1, 0);   chk("rst busy1", busy1, 0); chk("rst err1", err1, 0);
        chk("rst sce1", sce1, 0); chk("rst swe1", swe1, 0);
        chk("rst saddr1", saddr1, 0); chk("rst sdout1", sdout1, 0);
        chk("rst ok0", ok0, 0);   chk("rst busy0", busy0, 0); chk("rst sce0", sce0, 0);
        chk("rst ok3", ok3, 0);   chk("rst busy3", busy3, 0); chk("rst err3", err3, 0);
        chk("rst sdout3", sdout3, 0);
        tick(); tick();
        Rst = 1'b1;
        tick();

        // Read, WAIT_STATES=1
        Addr = 20'h01234; SDIn = 16'hBEEF; RRq = 1'b1;
        tick();
        chk("A sce1 e1", sce1, 1); chk("A swe1 e1", swe1, 0); chk("A saddr1", saddr1, 20'h01234);
        chk("A busy1", busy1, 1);  chk("A ok1 e1", ok1, 0);
        tick();
        chk("A sce1 e2", sce1, 1); chk("A ok1 e2", ok1, 0);
        tick();
        chk("A ok1 e3", ok1, 1); chk("A sce1 e3", sce1, 0); chk("A data1", data1, 16'hBEEF);
        tick();
        chk("A ok1 hold", ok1, 1); chk("A data1 hold", data1, 16'hBEEF);
        RRq = 1'b0;
        tick();
        chk("A ok1 drop", ok1, 0); chk("A busy1 drop", busy1, 0);
        chk("A data1 released", (data1 !== 16'hBEEF), 1);
        idle(5);

        // Write, WAIT_STATES=0
        Addr = 20'hFFFFF; drv = 16'h5A5A; drv_en = 1'b1; WRq = 1'b1;
        tick();
        chk("B sce0", sce0, 1); chk("B swe0", swe0, 1); chk("B saddr0", saddr0, 20'hFFFFF);
        chk("B sdout0", sdout0, 16'h5A5A); chk("B ok0 e1", ok0, 0); chk("B data0 e1", data0, 16'h5A5A);
        tick();
        chk("B ok0 e2", ok0, 1); chk("B sce0 e2", sce0, 0); chk("B swe0 e2", swe0, 0);
        chk("B data0 e2", data0, 16'h5A5A);
        WRq = 1'b0; drv_en = 1'b0;
        tick();
        chk("B ok0 drop", ok0, 0); chk("B err0", err0, 0);
        idle(6);

        // Both requests high: read wins, Err set; swapping request mid-ACCESS is ignored.
        Addr = 20'h00ABC; SDIn = 16'h1234; RRq = 1'b1; WRq = 1'b1;
        tick();
        chk("C err1", err1, 1); chk("C swe1", swe1, 0); chk("C sce1", sce1, 1);
        chk("C sdout1 kept", sdout1, 16'h5A5A);
        RRq = 1'b0;
        tick();
        chk("C swe1 after swap", swe1, 0);
        tick();
        chk("C ok1", ok1, 1); chk("C data1", data1, 16'h1234);
        WRq = 1'b0;
        tick();
        chk("C ok1 drop", ok1, 0);
        idle(6);

        // Clean write after the error; Err must stay set.
        Addr = 20'h00001; drv = 16'h0F0F; drv_en = 1'b1; WRq = 1'b1;
        n = 0;
        while (!ok1 && n < 20) begin tick(); n++; end
        chk("C2 write latency1", n, 3);
        chk("C2 sdout1", sdout1, 16'h0F0F); chk("C2 saddr1", saddr1, 20'h00001);
        WRq = 1'b0; drv_en = 1'b0;
        tick();
        chk("C2 ok1 drop", ok1, 0); chk("C2 err1 sticky", err1, 1);
        idle(6);

        // Reset mid-ACCESS of a write, WAIT_STATES=3
        Addr = 20'h00055; drv = 16'hAAAA; drv_en = 1'b1; WRq = 1'b1;
        tick();
        chk("D sce3", sce3, 1); chk("D swe3", swe3, 1);
        tick();
        #2 Rst = 1'b0;
        #1;
        chk("D sce3 async", sce3, 0); chk("D swe3 async", swe3, 0); chk("D busy3 async", busy3, 0);
        chk("D ok3 async", ok3, 0); chk("D saddr3 async", saddr3, 0); chk("D err1 cleared", err1, 0);
        #1 Rst = 1'b1;
        WRq = 1'b0; drv_en = 1'b0;
        seen_swe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen_swe = seen_swe | swe3;
            chk("D no stale ok3", ok3, 0);
        end
        chk("D no swe3 pulse", seen_swe, 0);

        // Read after reset completes normally; this OK also starts the back-to-back run.
        Addr = 20'h00077; SDIn = 16'hC0DE; RRq = 1'b1;
        n = 0;
        while (!ok3 && n < 20) begin tick(); n++; end
        chk("D read latency3", n, 5); chk("D data3", data3, 16'hC0DE); chk("D saddr3", saddr3, 20'h00077);
        cyc_a = cyc;

        // Requester behaves as registered logic: drops RRq the edge after seeing OK,
        // and re-raises it the edge OK is seen low.
        tick(); RRq = 1'b0;
        tick();
        chk("E ok3 low", ok3, 0);
        RRq = 1'b1; Addr = 20'h00200; SDIn = 16'h0042;
        tick();
        chk("E saddr3 latched", saddr3, 20'h00200);
        Addr = 20'h3FFFF;
        tick();
        chk("E saddr3 mid-access", saddr3, 20'h00200);
        n = 0;
        while (!ok3 && n < 20) begin tick(); n++; end
        chk("E period 1", cyc - cyc_a, 7); chk("E data3", data3, 16'h0042);
        cyc_a = cyc;
        tick(); RRq = 1'b0;
        tick();
        RRq = 1'b1; Addr = 20'h00300;
        n = 0;
        while (!ok3 && n < 20) begin tick(); n++; end
        chk("E period 2", cyc - cyc_a, 7); chk("E saddr3 second", saddr3, 20'h00300);
        tick(); RRq = 1'b0;
        tick();
        chk("E ok3 final drop", ok3, 0); chk("E busy3 final", busy3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
